// File: rtl/data_source_seq.sv
// Paced test-pattern source: N_DATA words per loop over N_LOOPS loops, one word every SENDNTH cycles.
// Define DATA_SOURCE_REPEAT_EN to wrap back to the first loop forever instead of stopping.
module data_source_seq #(
    parameter int SENDNTH    = 4,
    parameter int LOGSENDNTH = 2,
    parameter int N_LOOPS    = 2,
    parameter int LOGNLOOPS  = 1,
    parameter int WIDTH      = 32,
    parameter int MWIDTH     = 1,
    parameter int N_DATA     = 8,
    parameter int LOGNDATA   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              out_nd,
    output logic [WIDTH-1:0]  out_data,
    output logic [MWIDTH-1:0] out_m,
    output logic              error
);

    localparam logic BAD = (SENDNTH == 0) || (SENDNTH > (1 << LOGSENDNTH)) ||
                           (N_DATA == 0)  || (N_DATA > (1 << LOGNDATA)) ||
                           (N_LOOPS == 0) || (N_LOOPS > (1 << LOGNLOOPS));

    // Terminal counts; only meaningful when the parameters are consistent.
    localparam logic [LOGSENDNTH-1:0] P_LAST = LOGSENDNTH'(SENDNTH - 1);
    localparam logic [LOGNDATA-1:0]   I_LAST = LOGNDATA'(N_DATA - 1);
    localparam logic [LOGNLOOPS-1:0]  L_LAST = LOGNLOOPS'(N_LOOPS - 1);

    typedef enum logic {RUN, DONE} state_t;

    state_t                state, state_nxt;
    logic [LOGSENDNTH-1:0] p, p_nxt;
    logic [LOGNDATA-1:0]   i, i_nxt;
    logic [LOGNLOOPS-1:0]  l, l_nxt;
    logic [LOGNDATA:0]     i_inc;
    logic                  out_nd_nxt, error_nxt;
    logic [WIDTH-1:0]      out_data_nxt;
    logic [MWIDTH-1:0]     out_m_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            p        <= '0;
            i        <= '0;
            l        <= '0;
            out_nd   <= 1'b0;
            out_data <= '0;
            out_m    <= '0;
            error    <= 1'b0;
        end else begin
            state    <= state_nxt;
            p        <= p_nxt;
            i        <= i_nxt;
            l        <= l_nxt;
            out_nd   <= out_nd_nxt;
            out_data <= out_data_nxt;
            out_m    <= out_m_nxt;
            error    <= error_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        p_nxt        = p;
        i_nxt        = i;
        l_nxt        = l;
        out_nd_nxt   = 1'b0;
        out_data_nxt = out_data;
        out_m_nxt    = out_m;
        error_nxt    = error | BAD;
        // Extra bit so i+1 is exact even when N_DATA == 2^LOGNDATA.
        i_inc        = {1'b0, i} + (LOGNDATA + 1)'(1);

        if (state == RUN && !BAD) begin
            if (p == P_LAST) begin
                p_nxt        = '0;
                out_nd_nxt   = 1'b1;
                out_data_nxt = WIDTH'(i_inc);
                out_m_nxt    = MWIDTH'(l);
                if (i == I_LAST) begin
                    i_nxt = '0;
                    if (l == L_LAST) begin
`ifdef DATA_SOURCE_REPEAT_EN
                        l_nxt = '0;
`else
                        state_nxt = DONE;
`endif
                    end else begin
                        l_nxt = l + LOGNLOOPS'(1);
                    end
                end else begin
                    i_nxt = i + LOGNDATA'(1);
                end
            end else begin
                p_nxt = p + LOGSENDNTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_data_source_seq.sv
// Bench for data_source_seq: four parameterisations against a cycle-count based reference model,
// with randomly timed asynchronous resets.
module tb_data_source_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // d0 defaults, d1 every-cycle single loop, d2 bad pacing, d3 narrow data
    logic        nd0, nd1, nd2, nd3;
    logic [31:0] data0, data1, data2;
    logic [1:0]  data3;
    logic        m0, m1, m2, m3;
    logic        err0, err1, err2, err3;

    data_source_seq u_d0 (.clk(clk), .rst_n(rst_n), .out_nd(nd0), .out_data(data0), .out_m(m0), .error(err0));
    data_source_seq #(.SENDNTH(1), .LOGSENDNTH(1), .N_DATA(4), .N_LOOPS(1)) u_d1
        (.clk(clk), .rst_n(rst_n), .out_nd(nd1), .out_data(data1), .out_m(m1), .error(err1));
    data_source_seq #(.SENDNTH(5), .LOGSENDNTH(2)) u_d2
        (.clk(clk), .rst_n(rst_n), .out_nd(nd2), .out_data(data2), .out_m(m2), .error(err2));
    data_source_seq #(.WIDTH(2)) u_d3
        (.clk(clk), .rst_n(rst_n), .out_nd(nd3), .out_data(data3), .out_m(m3), .error(err3));

    int n_cmp = 0;
    int n_bad = 0;
    int c;  // rising edges since reset release

    always @(posedge clk or negedge rst_n)
        if (!rst_n) c <= 0;
        else        c <= c + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (c=%0d t=%0t)", tag, obs, exp, c, $time);
        end
    endtask

    // Word k (1-based) is issued on edge k*s; its data is its position within the loop.
    function automatic void model(input int cyc, input int s, input int nd, input int nl,
                                  input int w, input int mw, input bit bad,
                                  output bit e_nd, output longint e_data,
                                  output longint e_m, output bit e_err);
        longint k;
        longint tot;
        tot   = nd * nl;
        e_err = bad && (cyc >= 1);
        k     = bad ? 0 : cyc / s;
`ifndef DATA_SOURCE_REPEAT_EN
        if (k > tot) k = tot;
`endif
        e_nd = !bad && cyc > 0 && (cyc % s == 0) && (k == cyc / s);
        if (k == 0) begin
            e_data = 0;
            e_m    = 0;
        end else begin
            e_data = ((k - 1) % nd + 1) & ((64'(1) << w) - 1);
            e_m    = (((k - 1) / nd) % nl) & ((64'(1) << mw) - 1);
        end
    endfunction

    task automatic check_one(input string name, input int s, input int nd, input int nl,
                             input int w, input bit bad, input logic o_nd,
                             input longint o_data, input logic o_m, input logic o_err);
        bit e_nd, e_err;
        longint e_data, e_m;
        model(c, s, nd, nl, w, 1, bad, e_nd, e_data, e_m, e_err);
        chk({name, "_nd"}, o_nd, e_nd);
        chk({name, "_data"}, o_data, e_data);
        chk({name, "_m"}, o_m, e_m);
        chk({name, "_err"}, o_err, e_err);
    endtask

    always @(negedge clk) begin
        check_one("d0", 4, 8, 2, 32, 1'b0, nd0, data0, m0, err0);
        check_one("d1", 1, 4, 1, 32, 1'b0, nd1, data1, m1, err1);
        check_one("d2", 5, 8, 2, 32, 1'b1, nd2, data2, m2, err2);
        check_one("d3", 4, 8, 2, 2,  1'b0, nd3, data3, m3, err3);
    end

    initial begin
        int len;
        repeat (2) @(negedge clk);
        for (int ep = 0; ep < 6; ep++) begin
            rst_n = 1'b1;
            len = (ep % 2 == 0) ? 80 : $urandom_range(6, 60);
            repeat (len) @(negedge clk);
            // Mid-cycle reset: outputs must clear without waiting for an edge.
            #2 rst_n = 1'b0;
            #1;
            chk("async_nd0", nd0, 0);
            chk("async_data0", data0, 0);
            chk("async_m0", m0, 0);
            chk("async_data1", data1, 0);
            chk("async_err2", err2, 0);
            chk("async_data3", data3, 0);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_source_seq.md
Name: data_source_seq

Overview:
- Deterministic test-pattern generator for the SDR datapath benches.
- Emits N_DATA words per loop, N_LOOPS loops, one word every SENDNTH clock cycles, each flagged by a single-cycle out_nd strobe.
- Carries loop index as metadata on out_m.
- error reports inconsistent parameterisation.

Parameters:
- SENDNTH, 4: cycles per emitted word (1 = every cycle); valid range 1..2^LOGSENDNTH.
- LOGSENDNTH, 2: width of the pacing counter; must be at least 1.
- N_LOOPS, 2: number of passes over the data set; valid range 1..2^LOGNLOOPS.
- LOGNLOOPS, 1: width of the loop counter; must be at least 1.
- WIDTH, 32: out_data width.
- MWIDTH, 1: out_m width.
- N_DATA, 8: words per loop; valid range 1..2^LOGNDATA.
- LOGNDATA, 3: width of the word-index counter; must be at least 1.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- out_nd, output, 1: new-data strobe, high exactly one cycle per word.
- out_data, output, WIDTH: data word, valid when out_nd=1.
- out_m, output, MWIDTH: metadata (loop index), valid when out_nd=1.
- error, output, 1: sticky parameter-error flag.

Behaviour:
- Interface: one clock, clk; asynchronous active-low reset, rst_n.
- Reset (rst_n=0, asynchronous):
  - out_nd=0, out_data=0, out_m=0, error=0.
  - Pacing counter p=0, index i=0, loop l=0, state RUN.
- Parameter check (combinational constant): bad = (SENDNTH==0) | (SENDNTH>2^LOGSENDNTH) | (N_DATA==0) | (N_DATA>2^LOGNDATA) | (N_LOOPS==0) | (N_LOOPS>2^LOGNLOOPS).
  - If bad: error rises on the first clock edge after reset release and stays high until the next reset.
  - While bad, out_nd never asserts.
- States: RUN, DONE.
- RUN, each edge:
  - If p==SENDNTH-1: p<=0, out_nd<=1, out_data<=(i+1) mod 2^WIDTH zero-extended, out_m<=l mod 2^MWIDTH; then advance the index.
  - Otherwise: p<=p+1, out_nd<=0.
- Index advance:
  - If i==N_DATA-1: i<=0. If l==N_LOOPS-1, go to DONE; otherwise l<=l+1.
  - Otherwise: i<=i+1.
- DONE: out_nd=0 forever; out_data and out_m hold the last emitted values; counters frozen.
- All outputs are registered.
  - out_data and out_m hold their values between strobes; they are not cleared when out_nd falls.
- Timing:
  - First word: out_nd high after the SENDNTH-th rising edge following reset release.
  - Strobes are exactly SENDNTH cycles apart.
  - With SENDNTH=1, out_nd stays continuously high for N_DATA*N_LOOPS cycles.
- Total words emitted: N_DATA*N_LOOPS.
- Reset mid-operation: immediate return to reset values; the sequence restarts from i=0, l=0 after release.
- Loop boundary: the last word of loop l is followed by data value 1 with out_m=l+1. There is no gap beyond the normal SENDNTH spacing.

Optional Feature:
- Macro: DATA_SOURCE_REPEAT_EN.
- Defined: DONE is never entered. After the last word of loop N_LOOPS-1, the block wraps to i=0, l=0 and continues indefinitely with unchanged spacing (next word data=1, out_m=0).
- Undefined: the block stops in DONE as described above.

Test Plan:
- Defaults (SENDNTH=4, N_DATA=8, N_LOOPS=2): release reset, count strobes.
  - out_nd high at cycles 4, 8, ..., 64 after release; 16 strobes total.
  - out_data sequence 1..8, 1..8; out_m 0 ×8, then 1 ×8.
  - No strobe after cycle 64; error=0 throughout.
- SENDNTH=1, LOGSENDNTH=1, N_DATA=4, N_LOOPS=1: out_nd high for 4 consecutive cycles starting cycle 1, data 1, 2, 3, 4; then low; out_data holds 4.
- Defaults, assert rst_n low after the 5th strobe: outputs go to 0 immediately without waiting for an edge. After release, the first strobe again carries data=1, out_m=0.
- SENDNTH=5 with LOGSENDNTH=2: error=1 one edge after reset release, out_nd never high; a new reset clears error, which then sets again.
- WIDTH=2, N_DATA=8, LOGNDATA=3: data wraps mod 4, giving the sequence 1, 2, 3, 0, 1, 2, 3, 0.
- DATA_SOURCE_REPEAT_EN defined, defaults: the 17th strobe at cycle 68 has data=1, out_m=0; strobes continue every 4 cycles.
